// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divider-sharing controller: state encoding,
// default operand width and the quotient returned for a zero divisor.
package div_ctrl_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_RESP  = ST_RESP
    } state_e;

    localparam logic [WIDTH_DEF-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_rr_pick.sv
// Combinational round-robin picker: the first valid requester after last_i,
// searching upward with wrap-around. Usable in front of any shared core.
module div_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         valid_i,
    input  logic [$clog2(N)-1:0] last_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);

    localparam int IDXW = $clog2(N);

    always_comb begin
        logic [IDXW-1:0] cand;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        // Offsets 1..N visit every requester once, ending on last_i itself.
        for (int i = 1; i <= N; i++) begin
            cand = IDXW'((int'(last_i) + i) % N);
            if (!any_o && valid_i[cand]) begin
                any_o       = 1'b1;
                idx_o       = cand;
                gnt_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one sequential divider core between NUM_REQ requesters, one operation
// at a time; a zero divisor is answered locally without starting the core.
module div_share_arbiter
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_dividend,
    input  logic [NUM_REQ*WIDTH-1:0]   req_divisor,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [WIDTH-1:0]           rsp_quotient,
    output logic [WIDTH-1:0]           rsp_remainder,
    output logic                       rsp_div_zero,
    output logic                       div_start,
    output logic [WIDTH-1:0]           div_dividend,
    output logic [WIDTH-1:0]           div_divisor,
    input  logic                       div_done,
    input  logic [WIDTH-1:0]           div_quotient,
    input  logic [WIDTH-1:0]           div_remainder,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [1:0]                 dbg_state
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid may not depend on ready, and once raised must be
    // held with stable data until the transfer.

    state_e               state_q;
    logic [IDW-1:0]       last_grant_q;
    logic [IDW-1:0]       grant_q;
    logic [WIDTH-1:0]     dvd_q;
    logic [WIDTH-1:0]     dvs_q;
    logic [WIDTH-1:0]     quo_q;
    logic [WIDTH-1:0]     rem_q;
    logic                 dz_q;
    logic                 start_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;

    logic [NUM_REQ-1:0]   pick_gnt;
    logic [IDW-1:0]       pick_idx;
    logic                 pick_any;
    logic [WIDTH-1:0]     sel_dvd;
    logic [WIDTH-1:0]     sel_dvs;

    div_rr_pick #(.N(NUM_REQ)) u_pick (
        .valid_i (req_valid),
        .last_i  (last_grant_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        sel_dvd = '0;
        sel_dvs = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDW'(i)) begin
                sel_dvd = req_dividend[i*WIDTH +: WIDTH];
                sel_dvs = req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    // Ready is gated by rst so nothing appears accepted while reset is held.
    assign req_ready = (rst && state_q == S_IDLE) ? pick_gnt : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDW'(NUM_REQ - 1);
            grant_q      <= '0;
            dvd_q        <= '0;
            dvs_q        <= '0;
            quo_q        <= '0;
            rem_q        <= '0;
            dz_q         <= 1'b0;
            start_q      <= 1'b0;
            rsp_valid_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        dvd_q   <= sel_dvd;
                        dvs_q   <= sel_dvs;
                        if (sel_dvs == '0) begin
                            quo_q       <= '1;
                            rem_q       <= sel_dvd;
                            dz_q        <= 1'b1;
                            rsp_valid_q <= pick_gnt;
                            state_q     <= S_RESP;
                        end else begin
                            start_q <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    start_q <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (div_done) begin
                        quo_q       <= div_quotient;
                        rem_q       <= div_remainder;
                        dz_q        <= 1'b0;
                        rsp_valid_q <= ONE << grant_q;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready[grant_q]) begin
                        last_grant_q <= grant_q;
                        rsp_valid_q  <= '0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_quotient  = quo_q;
    assign rsp_remainder = rem_q;
    assign rsp_div_zero  = dz_q;
    assign div_start     = start_q;
    assign div_dividend  = dvd_q;
    assign div_divisor   = dvs_q;
    assign busy          = (state_q != S_IDLE);
    assign grant_id      = grant_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: behavioural divider core with fixed latency,
// requester drivers and a scoreboard of expected responses.
module tb_div_share_arbiter;
  import div_ctrl_pkg::*;

  localparam int WIDTH   = 16;
  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;
  localparam int EW      = IDW + 1 + 2 * WIDTH;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_dividend;
  logic [NUM_REQ*WIDTH-1:0] req_divisor;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]         rsp_quotient;
  logic [WIDTH-1:0]         rsp_remainder;
  logic                     rsp_div_zero;
  logic                     div_start;
  logic [WIDTH-1:0]         div_dividend;
  logic [WIDTH-1:0]         div_divisor;
  logic                     div_done;
  logic [WIDTH-1:0]         div_quotient;
  logic [WIDTH-1:0]         div_remainder;
  logic                     busy;
  logic [IDW-1:0]           grant_id;
  logic [1:0]               dbg_state;

  int           n_checks = 0;
  int           n_err    = 0;
  int           core_lat = 3;
  int           start_cnt = 0;
  int           st_mark  = 0;
  logic         spur_done = 1'b0;
  logic [EW-1:0] exp_q[$];
  logic [WIDTH-1:0] op_a[NUM_REQ];
  logic [WIDTH-1:0] op_b[NUM_REQ];

  div_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_div_zero  (rsp_div_zero),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .busy          (busy),
    .grant_id      (grant_id),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err + 1);
    $fatal(1, "watchdog expired");
  end

  // divider core model: done pulses core_lat cycles after the start cycle
  initial begin
    int busy_cnt;
    logic [WIDTH-1:0] ca, cb;
    busy_cnt = 0;
    ca = '0;
    cb = 16'd1;
    div_done = 1'b0;
    div_quotient = '0;
    div_remainder = '0;
    forever begin
      @(negedge clk);
      #2;
      div_done = spur_done;
      if (spur_done) begin
        div_quotient  = 16'hDEAD;
        div_remainder = 16'hBEEF;
      end
      if (!rst) begin
        busy_cnt = 0;
        div_done = 1'b0;
      end else begin
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) begin
            div_done      = 1'b1;
            div_quotient  = ca / cb;
            div_remainder = ca % cb;
          end
        end
        if (div_start) begin
          start_cnt++;
          ca = div_dividend;
          cb = div_divisor;
          busy_cnt = core_lat;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic stop_now(input string tag);
    check_eq(tag, 64'd0, 64'd1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $fatal(1, "bounded wait expired");
  endtask

  // driver tasks
  task automatic set_req(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    op_a[id] = a;
    op_b[id] = b;
    req_dividend[id*WIDTH +: WIDTH] = a;
    req_divisor[id*WIDTH +: WIDTH]  = b;
    req_valid[id] = 1'b1;
  endtask

  task automatic wait_grant(output int g);
    int n;
    g = 0;
    n = 0;
    #1;
    while (req_ready == '0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (req_ready == '0) stop_now("grant_timeout");
    check_eq("ready_onehot", 64'($countones(req_ready)), 64'd1);
    for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g = i;
  endtask

  task automatic take(input int g);
    logic [EW-1:0] e;
    if (op_b[g] == '0) e = {IDW'(g), 1'b1, 16'hFFFF, op_a[g]};
    else e = {IDW'(g), 1'b0, op_a[g] / op_b[g], op_a[g] % op_b[g]};
    exp_q.push_back(e);
    st_mark = start_cnt;
    @(negedge clk);
    req_valid[g] = 1'b0;
    #1;
    check_eq("acc_grant_id", 64'(grant_id), 64'(g));
    check_eq("acc_dividend", 64'(div_dividend), 64'(op_a[g]));
    check_eq("acc_divisor", 64'(div_divisor), 64'(op_b[g]));
  endtask

  // scoreboard: pop the expected response when the DUT presents one
  task automatic collect(input int bp, input bit spur);
    logic [EW-1:0] e;
    logic [NUM_REQ-1:0] v0;
    logic [WIDTH-1:0] q0, r0;
    int n, id, starts;
    logic dz;
    n = 0;
    while (rsp_valid == '0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (rsp_valid == '0) stop_now("rsp_timeout");
    if (exp_q.size() == 0) begin
      check_eq("exp_empty", 64'd1, 64'd0);
      return;
    end
    e  = exp_q.pop_front();
    id = int'(e[EW-1 -: IDW]);
    dz = e[2*WIDTH];
    starts = dz ? 0 : 1;
    check_eq("rsp_latency", 64'(n), 64'(dz ? 0 : core_lat + 1));
    check_eq("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << id));
    check_eq("rsp_grant_id", 64'(grant_id), 64'(id));
    check_eq("rsp_quotient", 64'(rsp_quotient), 64'(e[2*WIDTH-1 -: WIDTH]));
    check_eq("rsp_remainder", 64'(rsp_remainder), 64'(e[WIDTH-1:0]));
    check_eq("rsp_div_zero", 64'(rsp_div_zero), 64'(dz));
    check_eq("start_count", 64'(start_cnt - st_mark), 64'(starts));
    v0 = rsp_valid;
    q0 = rsp_quotient;
    r0 = rsp_remainder;
    for (int k = 0; k < bp; k++) begin
      spur_done = spur && (k == 0);
      rsp_ready = ~(4'b0001 << id);
      @(negedge clk);
      #1;
      check_eq("bp_valid", 64'(rsp_valid), 64'(v0));
      check_eq("bp_quotient", 64'(rsp_quotient), 64'(q0));
      check_eq("bp_remainder", 64'(rsp_remainder), 64'(r0));
      check_eq("bp_req_ready", 64'(req_ready), 64'd0);
      check_eq("bp_start_count", 64'(start_cnt - st_mark), 64'(starts));
      check_eq("bp_busy", 64'(busy), 64'd1);
    end
    spur_done = 1'b0;
    rsp_ready = 4'b0001 << id;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    check_eq("rel_valid", 64'(rsp_valid), 64'd0);
    check_eq("rel_busy", 64'(busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    req_valid = '1;
    #1;
    check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check_eq({tag, "_quotient"}, 64'(rsp_quotient), 64'd0);
    check_eq({tag, "_remainder"}, 64'(rsp_remainder), 64'd0);
    check_eq({tag, "_div_zero"}, 64'(rsp_div_zero), 64'd0);
    check_eq({tag, "_div_start"}, 64'(div_start), 64'd0);
    check_eq({tag, "_div_dividend"}, 64'(div_dividend), 64'd0);
    check_eq({tag, "_div_divisor"}, 64'(div_divisor), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_grant_id"}, 64'(grant_id), 64'd0);
    check_eq({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
    req_valid = '0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    int g;
    logic [WIDTH-1:0] q_snap;
    rst = 1'b0;
    req_valid = '0;
    req_dividend = '0;
    req_divisor = '0;
    rsp_ready = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    release_reset();

    // single request
    set_req(0, 16'd100, 16'd7);
    wait_grant(g);
    check_eq("single_grant", 64'(g), 64'd0);
    take(g);
    collect(0, 1'b0);

    // divide by zero answered locally
    set_req(1, 16'd1234, 16'd0);
    wait_grant(g);
    check_eq("dz_grant", 64'(g), 64'd1);
    take(g);
    collect(2, 1'b0);

    // spurious done while idle
    q_snap = rsp_quotient;
    spur_done = 1'b1;
    @(negedge clk);
    #1;
    spur_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("spur_idle_busy", 64'(busy), 64'd0);
    check_eq("spur_idle_valid", 64'(rsp_valid), 64'd0);
    check_eq("spur_idle_quot", 64'(rsp_quotient), 64'(q_snap));
    check_eq("spur_idle_state", 64'(dbg_state), 64'(ST_IDLE));

    // backpressure with a competing request and a spurious done in RESP
    set_req(2, 16'd5000, 16'd13);
    wait_grant(g);
    check_eq("bp_grant", 64'(g), 64'd2);
    take(g);
    set_req(0, 16'd777, 16'd5);
    collect(5, 1'b1);
    wait_grant(g);
    check_eq("bp_next_grant", 64'(g), 64'd0);
    take(g);
    collect(0, 1'b0);

    // round robin from reset
    rst = 1'b0;
    check_reset_outputs("rr_reset");
    release_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'(1000 + i * 37), 16'd3);
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      check_eq("rr_order", 64'(g), 64'(k % NUM_REQ));
      take(g);
      collect(0, 1'b0);
      if (k < 4) set_req(g, 16'(2000 + k * 111 + g), 16'd3);
    end
    req_valid = '0;

    // reset while the core is busy
    core_lat = 20;
    set_req(3, 16'd4000, 16'd9);
    wait_grant(g);
    take(g);
    repeat (3) @(negedge clk);
    #1;
    check_eq("mid_state", 64'(dbg_state), 64'(ST_WAIT));
    rst = 1'b0;
    check_reset_outputs("mid_reset");
    exp_q.delete();
    release_reset();
    core_lat = 3;
    set_req(2, 16'd900, 16'd4);
    set_req(0, 16'd901, 16'd4);
    wait_grant(g);
    check_eq("post_reset_first", 64'(g), 64'd0);
    take(g);
    collect(0, 1'b0);
    wait_grant(g);
    check_eq("post_reset_second", 64'(g), 64'd2);
    take(g);
    collect(1, 1'b0);
    check_eq("exp_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
